dmem_arbiter: RTL and testbench

//  Shares one single-port data memory between the CPU MEM stage (port C) and a DMA/debug master (port D).

---
 rtl/dmem_arbiter.sv | 129 ++++++++++++
 tb/tb_dmem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the CPU MEM
// stage and a DMA/debug master, round-robin, one access at a time.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_id
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPT,
    DONE
  } state_t;

  localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

  state_t     state;
  state_t     state_nx;
  logic [2:0] cnt;
  logic [2:0] cnt_nx;
  logic       last_grant;
  logic       gnt_id;
  logic       lat_we;
  logic       any_req;
  logic       win;

  // win: 0 = CPU, 1 = DMA; ties go to whoever did not win last
  always_comb begin
    any_req = cpu_req | dma_req;
    win     = 1'b0;
    unique case (1'b1)
      cpu_req & dma_req:  win = ~last_grant;
      ~cpu_req & dma_req: win = 1'b1;
      default:            win = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (any_req) state_nx = ISSUE;
      end
      ISSUE: begin
        if (lat_we) begin
          state_nx = DONE;
        end else begin
          cnt_nx   = CNT_INIT;
          state_nx = (RD_LAT == 1) ? CAPT : WAIT;
        end
      end
      WAIT: begin
        cnt_nx = cnt - 3'd1;
        if (cnt == 3'd1) state_nx = CAPT;
      end
      CAPT: state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      last_grant <= 1'b1;
      gnt_id     <= 1'b0;
      lat_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == IDLE && any_req) begin
        gnt_id     <= win;
        last_grant <= win;
        lat_we     <= win ? dma_we : cpu_we;
        mem_addr   <= win ? dma_addr : cpu_addr;
        mem_wdata  <= win ? dma_wdata : cpu_wdata;
      end
      if (state == CAPT) begin
        if (gnt_id) dma_rdata <= mem_rdata;
        else        cpu_rdata <= mem_rdata;
      end
    end
  end

  assign mem_en    = (state == ISSUE);
  assign mem_we    = mem_en & lat_we;
  assign busy      = (state != IDLE);
  assign grant_id  = gnt_id;
  assign cpu_ack   = (state == DONE) & ~gnt_id;
  assign dma_ack   = (state == DONE) & gnt_id;
  assign cpu_stall = cpu_req & ~cpu_ack;

`ifndef SYNTHESIS
  a_rd_lat: assert property (@(posedge clk) (RD_LAT >= 1 && RD_LAT <= 7))
    else $error("dmem_arbiter: RD_LAT %0d out of range 1..7", RD_LAT);
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of arbitration, latency, rdata
// ownership and async reset abort, with a small latency memory model.
module tb_dmem_arbiter;

  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_ack, cpu_stall, dma_ack;
  logic        mem_en, mem_we, busy, grant_id;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int n_cpu_ack = 0;
  int n_dma_ack = 0;
  int n_dual = 0;
  int n_bad_we = 0;
  logic glog[$];

  bit [31:0] mem [64];
  bit [31:0] pipe_d [RD_LAT];
  bit        pipe_v [RD_LAT];

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // read data appears RD_LAT cycles after the mem_en cycle
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    pipe_v[0] <= mem_en && !mem_we;
    pipe_d[0] <= mem[mem_addr[7:2]];
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_d[i] <= pipe_d[i-1];
    end
  end

  assign mem_rdata = pipe_v[RD_LAT-1] ? pipe_d[RD_LAT-1] : 32'hBAD0BAD0;

  always @(negedge clk) begin
    if (cpu_ack) n_cpu_ack++;
    if (dma_ack) n_dma_ack++;
    if (cpu_ack && dma_ack) n_dual++;
    if (mem_we && !mem_en) n_bad_we++;
    if (mem_en) glog.push_back(grant_id);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic xact(input logic is_dma, input logic we,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output int lat, output int en_rel,
                      output logic en_we, output int stalls);
    int c0;
    logic ack;
    lat = -1;
    en_rel = -1;
    en_we = 1'b0;
    stalls = 0;
    @(posedge clk); #1;
    if (is_dma) begin
      dma_req = 1; dma_we = we; dma_addr = addr; dma_wdata = wdata;
    end else begin
      cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end
    c0 = cyc;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_en && en_rel < 0) begin
        en_rel = cyc - c0;
        en_we = mem_we;
      end
      if (cpu_stall) stalls++;
      ack = is_dma ? dma_ack : cpu_ack;
      if (ack) begin
        lat = cyc - c0;
        break;
      end
    end
    @(posedge clk); #1;
    cpu_req = 0;
    dma_req = 0;
  endtask

  initial begin
    int lat, en_rel, stalls, c0, acks, ca, da, cpu_rel, dma_rel;
    logic en_we, g;
    logic [31:0] a;

    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 | i;
    mem[32'h40 >> 2] = 32'hCAFE0040;
    mem[32'h10 >> 2] = 32'hDEADBEEF;
    mem[32'h50 >> 2] = 32'hC0C00001;
    mem[32'h54 >> 2] = 32'hD0D00002;
    mem[32'h60 >> 2] = 32'hAAAA5555;
    mem[32'h64 >> 2] = 32'h11112222;
    mem[32'h70 >> 2] = 32'h70707070;

    // 1: reset with both requests high
    rst_n = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40; cpu_wdata = 0;
    dma_req = 1; dma_we = 1; dma_addr = 32'h44; dma_wdata = 32'h99;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cpu_ack", 32'(cpu_ack), 0);
    chk("rst_dma_ack", 32'(dma_ack), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_dma_rdata", dma_rdata, 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    @(posedge clk); #1;
    rst_n = 1;
    c0 = cyc;
    en_rel = -1;
    g = 1'b1;
    a = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_en) begin
        en_rel = cyc - c0; g = grant_id; a = mem_addr;
        break;
      end
    end
    chk("t1_issue_cyc", en_rel, 1);
    chk("t1_first_grant", 32'(g), 0);
    chk("t1_mem_addr", a, 32'h40);
    lat = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cpu_ack) begin
        lat = cyc - c0;
        break;
      end
    end
    @(posedge clk); #1;
    cpu_req = 0;
    dma_req = 0;
    chk("t1_cpu_lat", lat, RD_LAT + 2);
    chk("t1_cpu_rdata", cpu_rdata, 32'hCAFE0040);
    chk("t1_no_dma_ack", n_dma_ack, 0);

    // 2: CPU read, RD_LAT=2
    xact(0, 0, 32'h10, 0, lat, en_rel, en_we, stalls);
    chk("t2_en_cyc", en_rel, 1);
    chk("t2_en_we", 32'(en_we), 0);
    chk("t2_ack_cyc", lat, 4);
    chk("t2_stall_cycles", stalls, 4);
    chk("t2_cpu_rdata", cpu_rdata, 32'hDEADBEEF);

    // 3: CPU write leaves cpu_rdata alone
    xact(0, 1, 32'h20, 32'h1234, lat, en_rel, en_we, stalls);
    chk("t3_en_cyc", en_rel, 1);
    chk("t3_en_we", 32'(en_we), 1);
    chk("t3_ack_cyc", lat, 2);
    chk("t3_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("t3_mem_word", mem[32'h20 >> 2], 32'h1234);

    // DMA write makes DMA the last grant before the fairness run
    xact(1, 1, 32'h30, 32'h55, lat, en_rel, en_we, stalls);
    chk("dw_ack_cyc", lat, 2);
    chk("dw_en_we", 32'(en_we), 1);
    chk("dw_mem_word", mem[32'h30 >> 2], 32'h55);
    chk("dw_dma_rdata", dma_rdata, 0);

    // 4: both requests held for four transactions
    glog.delete();
    ca = n_cpu_ack;
    da = n_dma_ack;
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h50;
    dma_req = 1; dma_we = 0; dma_addr = 32'h54;
    acks = 0;
    for (int i = 0; i < 40 && acks < 4; i++) begin
      @(negedge clk);
      if (cpu_ack) begin
        acks++;
        chk("t4_cpu_rdata", cpu_rdata, 32'hC0C00001);
      end
      if (dma_ack) begin
        acks++;
        chk("t4_dma_rdata", dma_rdata, 32'hD0D00002);
      end
    end
    @(posedge clk); #1;
    cpu_req = 0;
    dma_req = 0;
    repeat (3) @(negedge clk);
    chk("t4_grants", glog.size(), 4);
    if (glog.size() == 4) begin
      chk("t4_grant0", 32'(glog[0]), 0);
      chk("t4_grant1", 32'(glog[1]), 1);
      chk("t4_grant2", 32'(glog[2]), 0);
      chk("t4_grant3", 32'(glog[3]), 1);
    end
    chk("t4_cpu_acks", n_cpu_ack - ca, 2);
    chk("t4_dma_acks", n_dma_ack - da, 2);

    // 5: CPU request rises while a DMA read is in WAIT
    cpu_rel = -1;
    dma_rel = -1;
    cpu_we = 0; cpu_addr = 32'h64;
    dma_we = 0; dma_addr = 32'h60;
    for (int r = 0; r < 16; r++) begin
      @(posedge clk); #1;
      if (r == 0) dma_req = 1;
      if (r == 2) cpu_req = 1;
      if (dma_rel >= 0) dma_req = 0;
      if (cpu_rel >= 0) cpu_req = 0;
      @(negedge clk);
      if (r == 2) begin
        chk("t5_busy_wait", 32'(busy), 1);
        chk("t5_grant_wait", 32'(grant_id), 1);
      end
      if (dma_ack && dma_rel < 0) begin
        dma_rel = r;
        chk("t5_dma_rdata", dma_rdata, 32'hAAAA5555);
      end
      if (cpu_ack && cpu_rel < 0) cpu_rel = r;
    end
    chk("t5_dma_ack_cyc", dma_rel, 4);
    chk("t5_cpu_ack_cyc", cpu_rel, 9);
    chk("t5_cpu_rdata", cpu_rdata, 32'h11112222);
    chk("t5_dma_rdata_kept", dma_rdata, 32'hAAAA5555);

    // 6: reset pulse in the WAIT state of a CPU read
    ca = n_cpu_ack;
    for (int r = 0; r < 10; r++) begin
      @(posedge clk); #1;
      if (r == 0) begin
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h70;
      end
      if (r == 2) begin
        rst_n = 0;
        cpu_req = 0;
      end
      if (r == 3) rst_n = 1;
      @(negedge clk);
      if (r == 1) chk("t6_issue", 32'(mem_en), 1);
      if (r == 2) begin
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_mem_addr", mem_addr, 0);
        chk("t6_rst_cpu_rdata", cpu_rdata, 0);
        chk("t6_rst_dma_rdata", dma_rdata, 0);
      end
    end
    chk("t6_no_cpu_ack", n_cpu_ack - ca, 0);
    chk("t6_idle", 32'(busy), 0);
    xact(1, 1, 32'h74, 32'h77, lat, en_rel, en_we, stalls);
    chk("t6_dma_wr_cyc", lat, 2);
    chk("t6_mem_word", mem[32'h74 >> 2], 32'h77);

    chk("dual_ack", n_dual, 0);
    chk("we_without_en", n_bad_we, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
